z80_cycle_tracker: RTL and testbench
====================================

Z80_CYCLE_TRACKER -- requirements
Module: z80_cycle_tracker

Interface
REQ-001 SHALL have parameter FRAME_W, default 17, width of the frame T-state counter.
REQ-002 SHALL have port clkcpu  in  1  CPU clock, all state updates on its rising edge.
REQ-003 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports n_m1, n_mreq, n_iorq, n_rd, n_wr, n_rfsh, n_halt  in  1 each  raw Z80 strobes, active-low.
REQ-005 SHALL have port n_int  in  1  CPU interrupt line as driven to the CPU, active-low.
REQ-006 SHALL have port int_missed_clr  in  1  clears the int_missed flag.
REQ-007 SHALL have port cycle_type  out  3  current machine-cycle state encoding (see REQ-010).
REQ-008 SHALL have ports cycle_start  out  1  one-clock pulse on entry to a non-IDLE state; intack  out  1  one-clock pulse on entry to INTACK.
REQ-009 SHALL have ports tstate  out  3  T-state within the cycle; frame_tstate  out  FRAME_W  T-states since INT start; halted  out  1; int_missed  out  1  sticky flag.

Function
REQ-010 SHALL implement the state machine IDLE=0, OPFETCH=1, MEMRD=2, MEMWR=3, IORD=4, IOWR=5, INTACK=6, REFRESH=7, output directly on cycle_type.
REQ-011 SHALL register all Z80 strobes once on clkcpu and decode only the registered (active-high) copies.
REQ-012 SHALL decode the next state in priority order: m1&iorq->INTACK; m1&mreq->OPFETCH; rfsh&mreq->REFRESH; mreq&wr->MEMWR; mreq&rd->MEMRD; iorq&wr->IOWR; iorq&rd->IORD; otherwise IDLE.
REQ-013 SHALL update state every clock to the decoded value; a direct change between two non-IDLE states (e.g. OPFETCH->REFRESH) SHALL count as a new cycle.
REQ-014 SHALL assert cycle_start for exactly one clock, in the clock after the state register takes a new non-IDLE value differing from its previous value.
REQ-015 SHALL assert intack for exactly one clock, coincident with cycle_start of an INTACK cycle.
REQ-016 SHALL load tstate with 1 on each new cycle, increment it each clock while the state is unchanged, saturate at 7, and hold 0 in IDLE.
REQ-017 SHALL detect an n_int falling edge from the registered n_int copy (previous 1, current 0) and load frame_tstate with 0 on that clock.
REQ-018 SHALL otherwise increment frame_tstate every clock, saturating at all-ones without wrap.
REQ-019 SHALL drive halted from the registered ~n_halt, one clock latency.
REQ-020 SHALL set an internal seen_ack bit on any intack during the n_int low period and clear it on the n_int falling edge.
REQ-021 SHALL set int_missed on an n_int rising edge when seen_ack is 0.
REQ-022 SHALL clear int_missed on int_missed_clr; set SHALL win if both occur on the same clock.
REQ-023 SHALL treat a new n_int falling edge in the same clock as an intack as a fresh period (seen_ack=0).

Reset
REQ-024 SHALL on rst_n low asynchronously set state=IDLE, cycle_start=0, intack=0, tstate=0, frame_tstate=0, halted=0, int_missed=0, seen_ack=0, and registered strobes to inactive (n_int copy=1).
REQ-025 SHALL, after rst_n is released mid-cycle with strobes active, decode normally, so the first cycle_start occurs two clocks after release.

Verification
REQ-026 SHALL cover the opcode fetch: n_m1=n_mreq=n_rd=0 for 2 clocks, then n_m1 and n_rd high with n_rfsh=n_mreq=0 for 2 clocks -> cycle_type 1 then 7, two cycle_start pulses, tstate 1,2,1,2.
REQ-027 SHALL cover the interrupt acknowledge: n_int low, then n_m1=n_iorq=0 -> cycle_type=6, intack one pulse; n_int release -> int_missed stays 0.
REQ-028 SHALL cover the missed interrupt: n_int low for 32 clocks with no acknowledge, then released -> int_missed=1 until int_missed_clr, then 0.
REQ-029 SHALL cover the frame counter: n_int falls -> frame_tstate=0, reads 69887 after 69887 more clocks; with FRAME_W=4 it sticks at 15.
REQ-030 SHALL cover reset mid-IOWR: rst_n pulsed low while n_iorq=n_wr=0 -> all outputs at reset values immediately; cycle_type=5 with cycle_start two clocks after release.
REQ-031 SHALL cover a long wait: MEMRD held 10 clocks -> tstate 1..7 then holds 7; return to IDLE -> tstate=0.

Source files
------------

// File: rtl/z80_cycle_tracker.sv
// Classifies Z80 bus activity into machine cycles, tracks T-states within each
// cycle and within the interrupt frame, and flags interrupts that were never acknowledged.
module z80_cycle_tracker #(
   parameter int FRAME_W = 17
) (
   input  logic               clkcpu,
   input  logic               rst_n,
   input  logic               n_m1,
   input  logic               n_mreq,
   input  logic               n_iorq,
   input  logic               n_rd,
   input  logic               n_wr,
   input  logic               n_rfsh,
   input  logic               n_halt,
   input  logic               n_int,
   input  logic               int_missed_clr,
   output logic [2:0]         cycle_type,
   output logic               cycle_start,
   output logic               intack,
   output logic [2:0]         tstate,
   output logic [FRAME_W-1:0] frame_tstate,
   output logic               halted,
   output logic               int_missed
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      OPFETCH = 3'd1,
      MEMRD   = 3'd2,
      MEMWR   = 3'd3,
      IORD    = 3'd4,
      IOWR    = 3'd5,
      INTACK  = 3'd6,
      REFRESH = 3'd7
   } state_t;

   state_t state, state_nxt;

   logic m1_q, mreq_q, iorq_q, rd_q, wr_q, rfsh_q;
   logic n_int_q, n_int_prev;
   logic seen_ack;
   logic new_cycle, int_fall, int_rise;

   // Active-high registered copies of the strobes; all decoding uses these.
   always_ff @(posedge clkcpu or negedge rst_n) begin
      if (!rst_n) begin
         m1_q       <= 1'b0;
         mreq_q     <= 1'b0;
         iorq_q     <= 1'b0;
         rd_q       <= 1'b0;
         wr_q       <= 1'b0;
         rfsh_q     <= 1'b0;
         halted     <= 1'b0;
         n_int_q    <= 1'b1;
         n_int_prev <= 1'b1;
      end else begin
         m1_q       <= ~n_m1;
         mreq_q     <= ~n_mreq;
         iorq_q     <= ~n_iorq;
         rd_q       <= ~n_rd;
         wr_q       <= ~n_wr;
         rfsh_q     <= ~n_rfsh;
         halted     <= ~n_halt;
         n_int_q    <= n_int;
         n_int_prev <= n_int_q;
      end
   end

   always_comb begin
      state_nxt = IDLE;
      if (m1_q && iorq_q)        state_nxt = INTACK;
      else if (m1_q && mreq_q)   state_nxt = OPFETCH;
      else if (rfsh_q && mreq_q) state_nxt = REFRESH;
      else if (mreq_q && wr_q)   state_nxt = MEMWR;
      else if (mreq_q && rd_q)   state_nxt = MEMRD;
      else if (iorq_q && wr_q)   state_nxt = IOWR;
      else if (iorq_q && rd_q)   state_nxt = IORD;
   end

   assign new_cycle = (state_nxt != IDLE) && (state_nxt != state);
   assign int_fall  = n_int_prev && !n_int_q;
   assign int_rise  = !n_int_prev && n_int_q;

   always_ff @(posedge clkcpu or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         cycle_start <= 1'b0;
         intack      <= 1'b0;
         tstate      <= '0;
      end else begin
         state       <= state_nxt;
         cycle_start <= new_cycle;
         intack      <= new_cycle && (state_nxt == INTACK);
         if (state_nxt == IDLE)
            tstate <= '0;
         else if (new_cycle)
            tstate <= 3'd1;
         else if (tstate != 3'd7)
            tstate <= tstate + 3'd1;
      end
   end

   always_ff @(posedge clkcpu or negedge rst_n) begin
      if (!rst_n) begin
         frame_tstate <= '0;
      end else if (int_fall) begin
         frame_tstate <= '0;
      end else if (frame_tstate != '1) begin
         frame_tstate <= frame_tstate + {{(FRAME_W-1){1'b0}}, 1'b1};
      end
   end

   // A falling edge opens a fresh interrupt period even if intack lands on the same clock.
   always_ff @(posedge clkcpu or negedge rst_n) begin
      if (!rst_n) begin
         seen_ack   <= 1'b0;
         int_missed <= 1'b0;
      end else begin
         if (int_fall)
            seen_ack <= 1'b0;
         else if (intack && !n_int_q)
            seen_ack <= 1'b1;
         if (int_rise && !seen_ack)
            int_missed <= 1'b1;
         else if (int_missed_clr)
            int_missed <= 1'b0;
      end
   end

   assign cycle_type = state;

endmodule

// File: tb/tb_z80_cycle_tracker.sv
// Directed and randomized bench for z80_cycle_tracker against a history-based reference model.
module tb_z80_cycle_tracker;

   logic        clkcpu = 1'b0;
   logic        rst_n  = 1'b0;
   logic        n_m1 = 1'b1, n_mreq = 1'b1, n_iorq = 1'b1, n_rd = 1'b1;
   logic        n_wr = 1'b1, n_rfsh = 1'b1, n_halt = 1'b1, n_int = 1'b1;
   logic        int_missed_clr = 1'b0;
   logic [2:0]  cycle_type, cycle_type4;
   logic        cycle_start, intack, halted, int_missed;
   logic        cycle_start4, intack4, halted4, int_missed4;
   logic [2:0]  tstate, tstate4;
   logic [16:0] frame_tstate;
   logic [3:0]  frame_tstate4;

   int errors = 0;
   int checks = 0;

   always #5 clkcpu = ~clkcpu;

   z80_cycle_tracker u_dut (
      .clkcpu(clkcpu), .rst_n(rst_n), .n_m1(n_m1), .n_mreq(n_mreq), .n_iorq(n_iorq),
      .n_rd(n_rd), .n_wr(n_wr), .n_rfsh(n_rfsh), .n_halt(n_halt), .n_int(n_int),
      .int_missed_clr(int_missed_clr), .cycle_type(cycle_type), .cycle_start(cycle_start),
      .intack(intack), .tstate(tstate), .frame_tstate(frame_tstate), .halted(halted),
      .int_missed(int_missed)
   );

   z80_cycle_tracker #(.FRAME_W(4)) u_dut4 (
      .clkcpu(clkcpu), .rst_n(rst_n), .n_m1(n_m1), .n_mreq(n_mreq), .n_iorq(n_iorq),
      .n_rd(n_rd), .n_wr(n_wr), .n_rfsh(n_rfsh), .n_halt(n_halt), .n_int(n_int),
      .int_missed_clr(int_missed_clr), .cycle_type(cycle_type4), .cycle_start(cycle_start4),
      .intack(intack4), .tstate(tstate4), .frame_tstate(frame_tstate4), .halted(halted4),
      .int_missed(int_missed4)
   );

   // Reference model: history of sampled inputs plus run lengths and counters.
   bit [5:0]   hist_str;     // strobes seen one edge ago, active-high {m1,mreq,iorq,rd,wr,rfsh}
   bit         hist_int1, hist_int2;
   int         m_state, m_run;
   bit         m_cs, m_ia, m_halted, m_seen, m_missed;
   longint     m_frame;

   function automatic int decode(input bit [5:0] s);
      bit m1, mreq, iorq, rd, wr, rfsh;
      {m1, mreq, iorq, rd, wr, rfsh} = s;
      if (m1 && iorq)   return 6;
      if (m1 && mreq)   return 1;
      if (rfsh && mreq) return 7;
      if (mreq && wr)   return 3;
      if (mreq && rd)   return 2;
      if (iorq && wr)   return 5;
      if (iorq && rd)   return 4;
      return 0;
   endfunction

   function automatic longint lmin(input longint a, input longint b);
      return (a < b) ? a : b;
   endfunction

   task automatic model_reset();
      hist_str = '0; hist_int1 = 1'b1; hist_int2 = 1'b1;
      m_state = 0; m_run = 0; m_cs = 0; m_ia = 0; m_halted = 0;
      m_seen = 0; m_missed = 0; m_frame = 0;
   endtask

   task automatic model_edge();
      int nxt;
      bit fall, rise, seen_n, missed_n;
      nxt  = decode(hist_str);
      fall = hist_int2 && !hist_int1;
      rise = !hist_int2 && hist_int1;
      seen_n   = fall ? 1'b0 : ((m_ia && !hist_int1) ? 1'b1 : m_seen);
      missed_n = (rise && !m_seen) ? 1'b1 : (int_missed_clr ? 1'b0 : m_missed);
      m_cs = (nxt != 0) && (nxt != m_state);
      m_ia = m_cs && (nxt == 6);
      m_run = (nxt == 0) ? 0 : (m_cs ? 1 : m_run + 1);
      m_state = nxt;
      m_frame = fall ? 0 : m_frame + 1;
      m_seen = seen_n;
      m_missed = missed_n;
      m_halted = !n_halt;
      hist_str = {!n_m1, !n_mreq, !n_iorq, !n_rd, !n_wr, !n_rfsh};
      hist_int2 = hist_int1;
      hist_int1 = n_int;
   endtask

   task automatic chk(input string tag, input longint obs, input longint exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("cycle_type", cycle_type, m_state);
      chk("cycle_start", cycle_start, m_cs);
      chk("intack", intack, m_ia);
      chk("tstate", tstate, lmin(m_run, 7));
      chk("frame_tstate", frame_tstate, lmin(m_frame, 131071));
      chk("frame_tstate_w4", frame_tstate4, lmin(m_frame, 15));
      chk("halted", halted, m_halted);
      chk("int_missed", int_missed, m_missed);
   endtask

   task automatic step();
      @(posedge clkcpu);
      model_edge();
      #1;
      check_all();
      @(negedge clkcpu);
   endtask

   task automatic bus_idle();
      n_m1 = 1; n_mreq = 1; n_iorq = 1; n_rd = 1; n_wr = 1; n_rfsh = 1;
   endtask

   int ct_seq[6], ts_seq[6], cs_seq[6];
   int exp_ct[6] = '{0, 1, 1, 7, 7, 0};
   int exp_ts[6] = '{0, 1, 2, 1, 2, 0};
   int exp_cs[6] = '{0, 1, 0, 1, 0, 0};
   int pulses;
   bit saw_intack_state;

   initial begin
      model_reset();
      #12;
      chk("reset_cycle_type", cycle_type, 0);
      chk("reset_tstate", tstate, 0);
      chk("reset_frame", frame_tstate, 0);
      chk("reset_int_missed", int_missed, 0);
      @(negedge clkcpu);
      rst_n = 1'b1;
      step();

      // Opcode fetch followed directly by refresh.
      n_m1 = 0; n_mreq = 0; n_rd = 0;
      step(); ct_seq[0] = cycle_type; ts_seq[0] = tstate; cs_seq[0] = cycle_start;
      step(); ct_seq[1] = cycle_type; ts_seq[1] = tstate; cs_seq[1] = cycle_start;
      n_m1 = 1; n_rd = 1; n_rfsh = 0;
      step(); ct_seq[2] = cycle_type; ts_seq[2] = tstate; cs_seq[2] = cycle_start;
      step(); ct_seq[3] = cycle_type; ts_seq[3] = tstate; cs_seq[3] = cycle_start;
      bus_idle();
      step(); ct_seq[4] = cycle_type; ts_seq[4] = tstate; cs_seq[4] = cycle_start;
      step(); ct_seq[5] = cycle_type; ts_seq[5] = tstate; cs_seq[5] = cycle_start;
      for (int i = 0; i < 6; i++) begin
         chk($sformatf("opfetch_type[%0d]", i), ct_seq[i], exp_ct[i]);
         chk($sformatf("opfetch_tstate[%0d]", i), ts_seq[i], exp_ts[i]);
         chk($sformatf("opfetch_start[%0d]", i), cs_seq[i], exp_cs[i]);
      end

      // Acknowledged interrupt.
      n_int = 0;
      step(); step(); step();
      pulses = 0; saw_intack_state = 0;
      n_m1 = 0; n_iorq = 0;
      for (int i = 0; i < 6; i++) begin
         if (i == 2) bus_idle();
         step();
         pulses += int'(intack);
         if (cycle_type == 3'd6) saw_intack_state = 1;
      end
      chk("intack_pulses", pulses, 1);
      chk("intack_state_seen", saw_intack_state, 1);
      n_int = 1;
      step(); step(); step();
      chk("acked_int_missed", int_missed, 0);

      // Missed interrupt, then clear.
      n_int = 0;
      for (int i = 0; i < 32; i++) step();
      n_int = 1;
      step(); step(); step();
      chk("missed_set", int_missed, 1);
      int_missed_clr = 1;
      step();
      int_missed_clr = 0;
      step();
      chk("missed_cleared", int_missed, 0);

      // Long memory read wait states.
      n_mreq = 0; n_rd = 0;
      for (int i = 1; i <= 11; i++) begin
         step();
         if (i == 2) chk("wait_tstate_first", tstate, 1);
         if (i == 8) chk("wait_tstate_sat", tstate, 7);
      end
      chk("wait_tstate_hold", tstate, 7);
      chk("wait_type", cycle_type, 2);
      bus_idle();
      step(); step();
      chk("wait_idle_tstate", tstate, 0);

      // Reset pulsed in the middle of an IO write.
      n_iorq = 0; n_wr = 0;
      step();
      step();
      #2 rst_n = 0;
      #1;
      model_reset();
      chk("midrst_type", cycle_type, 0);
      chk("midrst_start", cycle_start, 0);
      chk("midrst_tstate", tstate, 0);
      chk("midrst_frame", frame_tstate, 0);
      #1 rst_n = 1;
      step();
      chk("midrst_first_idle", cycle_type, 0);
      step();
      chk("midrst_type_iowr", cycle_type, 5);
      chk("midrst_cycle_start", cycle_start, 1);
      bus_idle();
      step();

      // Randomized bus activity.
      for (int i = 0; i < 3000; i++) begin
         {n_m1, n_mreq, n_iorq, n_rd, n_wr, n_rfsh} = 6'($urandom);
         if ($urandom_range(0, 3) == 0) bus_idle();
         n_halt = ($urandom_range(0, 7) != 0);
         if ($urandom_range(0, 19) == 0) n_int = ~n_int;
         int_missed_clr = ($urandom_range(0, 15) == 0);
         step();
      end
      bus_idle(); n_halt = 1; int_missed_clr = 0; n_int = 1;
      step(); step(); step();

      // Frame counter across a full frame.
      n_int = 0;
      step(); step();
      chk("frame_zero", frame_tstate, 0);
      for (int i = 0; i < 69887; i++) step();
      chk("frame_69887", frame_tstate, 69887);
      chk("frame_w4_stuck", frame_tstate4, 15);
      n_int = 1;
      step(); step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
